// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end. Owns the architectural PC, keeps at
// most one instruction-memory read outstanding, and buffers returned words with
// their PC in a DEPTH-entry FIFO toward decode. Redirects (PCSrc) flush the
// buffer and discard any in-flight response.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect target traps to
// a halted state instead of being silently word-aligned).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic [31:0] pc,
    output logic        misalign_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;
`endif

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_next;
    logic [31:0]   r_addr;
    logic [31:0]   w_target;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_load_addr;
    logic [31:0]   r_buf_data [DEPTH];
    logic [31:0]   r_buf_pc   [DEPTH];

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;
    logic w_misalign_hit;
    logic w_halt;

    assign w_misalign_hit = PCSrc & (PCTarget[1:0] != 2'b00);
    assign w_halt         = r_misalign | w_misalign_hit;
    assign w_target       = PCTarget;
`else
    assign w_target       = PCTarget & 32'hFFFF_FFFC;
`endif

    // Buffer occupancy and PC update: a redirect overrides any same-cycle push or pop.
    always_comb begin
        w_push = (r_state == S_REQ) & imem_ack & ~PCSrc;
        w_pop  = r_valid & instr_ready;
        if (PCSrc) begin
            w_count_next = '0;
            w_pc_next    = w_target;
        end else begin
            w_count_next = r_count + CW'(w_push) - CW'(w_pop);
            w_pc_next    = w_push ? (r_pc + 32'd4) : r_pc;
        end
    end

    // Next-state decode; every entry into REQ latches the new fetch address from w_pc_next.
    always_comb begin
        w_state_next = r_state;
        w_load_addr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_count_next < DEPTH_C) begin
                    w_state_next = S_REQ;
                    w_load_addr  = 1'b1;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (w_count_next < DEPTH_C) begin
                        w_state_next = S_REQ;
                        w_load_addr  = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (PCSrc) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    w_state_next = S_REQ;
                    w_load_addr  = 1'b1;
                end
            end
            default: w_state_next = r_state;
        endcase
`ifdef MISALIGN_TRAP_EN
        // Halt overrides the normal decode, but only once no response is still owed.
        if (w_halt && (r_state == S_IDLE || r_state == S_HALT || imem_ack)) begin
            w_state_next = S_HALT;
            w_load_addr  = 1'b0;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, fetch address, occupancy and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_count <= '0;
            r_valid <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
            if (w_load_addr) begin
                r_addr <= w_pc_next;
            end
            if (PCSrc) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
            end
        end
    end

    // Instruction buffer storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_buf_data[r_wptr] <= imem_rdata;
            r_buf_pc[r_wptr]   <= r_addr;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_hit) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_err = r_misalign;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem_req       = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem_addr      = r_addr;
    assign instr_valid    = r_valid;
    assign instr_data     = r_buf_data[r_rptr];
    assign instr_pc       = r_buf_pc[r_rptr];
    assign instr_pc_plus4 = instr_pc + 32'd4;
    assign pc             = r_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus a randomized run checked against an
// instruction-stream model (expected next PC advanced on pops, reset on redirects).
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [31:0] pc;
    logic        misalign_err;

    // Second instance for the wrap-around reset PC, with a zero-wait memory.
    logic        req1;
    logic [31:0] addr1;
    logic        ack1;
    logic [31:0] rdata1;
    logic        ready1 = 1'b1;
    logic        pcsrc1 = 1'b0;
    logic [31:0] target1 = '0;
    logic        valid1;
    logic [31:0] data1;
    logic [31:0] ipc1;
    logic [31:0] ipc4_1;
    logic [31:0] pc1;
    logic        mis1;

    int checks = 0;
    int failures = 0;

    int unsigned lat_lo = 0;
    int unsigned lat_hi = 0;
    logic        slow_en = 1'b0;
    logic [31:0] slow_addr = '0;
    int unsigned slow_lat = 0;
    int unsigned wait_cnt = 0;
    int unsigned ack_count = 0;
    logic        busy = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
        .pc(pc), .misalign_err(misalign_err)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut1 (
        .clk(clk), .reset(reset), .PCSrc(pcsrc1), .PCTarget(target1),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1),
        .imem_rdata(rdata1), .instr_valid(valid1), .instr_ready(ready1),
        .instr_data(data1), .instr_pc(ipc1), .instr_pc_plus4(ipc4_1),
        .pc(pc1), .misalign_err(mis1)
    );

    assign ack1   = req1;
    assign rdata1 = mem_word(addr1);

    // Instruction memory: latency chosen per request, response driven at the falling edge.
    always @(negedge clk) begin
        if (reset || !imem_req) begin
            imem_ack = 1'b0;
            busy     = 1'b0;
            if (reset) ack_count = 0;
        end else begin
            if (!busy) begin
                busy     = 1'b1;
                wait_cnt = (slow_en && imem_addr == slow_addr) ? slow_lat : $urandom_range(lat_hi, lat_lo);
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                busy       = 1'b0;
                ack_count++;
            end else begin
                imem_ack = 1'b0;
                wait_cnt--;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        PCSrc       = 1'b0;
        PCTarget    = '0;
        instr_ready = rdy;
        reset       = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        lat_lo = 3; lat_hi = 3;
        PCSrc = 1'b0; instr_ready = 1'b1; reset = 1'b1;
        repeat (2) tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
        reset = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr: got %h expected 00000000", imem_addr); end
        // Reset while a slow request is outstanding abandons it.
        tick();
        reset = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL midreq_reset_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL midreq_reset_valid: got %b expected 0", instr_valid); end
        lat_lo = 0; lat_hi = 0;
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        tick();
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL stream_c0: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4)) begin failures++; $display("FAIL stream_pc%0d: got valid=%b pc=%h expected valid=1 pc=%h", k, instr_valid, instr_pc, 32'(k * 4)); end
            checks++; if (instr_data !== mem_word(32'(k * 4))) begin failures++; $display("FAIL stream_data%0d: got %h expected %h", k, instr_data, mem_word(32'(k * 4))); end
            checks++; if (imem_addr !== 32'(k * 4 + 4)) begin failures++; $display("FAIL stream_addr%0d: got %h expected %h", k, imem_addr, 32'(k * 4 + 4)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        repeat (5) tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req: got %b expected 0", imem_req); end
        checks++; if (ack_count !== 2) begin failures++; $display("FAIL bp_fetched: got %0d expected 2", ack_count); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=00000000", instr_valid, instr_pc); end
        tick();
        instr_ready = 1'b1;
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL bp_pop0: got %h expected 00000000", instr_pc); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin failures++; $display("FAIL bp_pop1: got valid=%b pc=%h expected valid=1 pc=00000004", instr_valid, instr_pc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
        tick();
        checks++; if (instr_pc !== 32'h8) begin failures++; $display("FAIL bp_pop2: got %h expected 00000008", instr_pc); end
    endtask

    task automatic test_redirect_drain();
        slow_en = 1'b1; slow_addr = 32'h8; slow_lat = 3;
        do_reset(1'b1);
        tick(); tick(); tick();
        PCSrc = 1'b1; PCTarget = 32'h100;
        checks++; if (instr_pc !== 32'h4 || imem_addr !== 32'h8 || imem_ack !== 1'b0) begin failures++; $display("FAIL drain_setup: got pc=%h addr=%h ack=%b expected pc=00000004 addr=00000008 ack=0", instr_pc, imem_addr, imem_ack); end
        tick();
        PCSrc = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL drain_flush: got %b expected 0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL drain_hold1: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL drain_pc: got %h expected 00000100", pc); end
        tick();
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL drain_hold2: got %h expected 00000008", imem_addr); end
        tick();
        checks++; if (imem_addr !== 32'h8 || imem_ack !== 1'b1) begin failures++; $display("FAIL drain_ack: got addr=%h ack=%b expected addr=00000008 ack=1", imem_addr, imem_ack); end
        tick();
        checks++; if (imem_addr !== 32'h100 || instr_valid !== 1'b0) begin failures++; $display("FAIL drain_newaddr: got addr=%h valid=%b expected addr=00000100 valid=0", imem_addr, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin failures++; $display("FAIL drain_first: got valid=%b pc=%h expected valid=1 pc=00000100", instr_valid, instr_pc); end
        checks++; if (instr_data !== mem_word(32'h100)) begin failures++; $display("FAIL drain_data: got %h expected %h", instr_data, mem_word(32'h100)); end
        checks++; if (pc !== 32'h104) begin failures++; $display("FAIL drain_pc_next: got %h expected 00000104", pc); end
        slow_en = 1'b0;
    endtask

    task automatic test_redirect_ack_pop();
        do_reset(1'b1);
        tick(); tick();
        PCSrc = 1'b1; PCTarget = 32'h200;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_ack !== 1'b1) begin failures++; $display("FAIL ap_setup: got valid=%b pc=%h ack=%b expected valid=1 pc=00000000 ack=1", instr_valid, instr_pc, imem_ack); end
        tick();
        PCSrc = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ap_flush: got %b expected 0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL ap_addr: got req=%b addr=%h expected req=1 addr=00000200", imem_req, imem_addr); end
        checks++; if (pc !== 32'h200) begin failures++; $display("FAIL ap_pc: got %h expected 00000200", pc); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin failures++; $display("FAIL ap_first: got valid=%b pc=%h expected valid=1 pc=00000200", instr_valid, instr_pc); end
        checks++; if (instr_pc_plus4 !== 32'h204) begin failures++; $display("FAIL ap_plus4: got %h expected 00000204", instr_pc_plus4); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        tick();
        checks++; if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first_addr: got req=%b addr=%h expected req=1 addr=fffffffc", req1, addr1); end
        tick();
        checks++; if (valid1 !== 1'b1 || ipc1 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_head: got valid=%b pc=%h expected valid=1 pc=fffffffc", valid1, ipc1); end
        checks++; if (ipc4_1 !== 32'h0) begin failures++; $display("FAIL wrap_plus4: got %h expected 00000000", ipc4_1); end
        checks++; if (addr1 !== 32'h0) begin failures++; $display("FAIL wrap_second_addr: got %h expected 00000000", addr1); end
        checks++; if (data1 !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_data: got %h expected %h", data1, mem_word(32'hFFFF_FFFC)); end
        tick();
        checks++; if (ipc1 !== 32'h0) begin failures++; $display("FAIL wrap_second_pc: got %h expected 00000000", ipc1); end
    endtask

    task automatic test_misalign();
        do_reset(1'b1);
        tick(); tick();
        PCSrc = 1'b1; PCTarget = 32'h102;
        tick();
        PCSrc = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mis_flush: got %b expected 0", instr_valid); end
`ifdef MISALIGN_TRAP_EN
        checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mis_err: got %b expected 1", misalign_err); end
        checks++; if (pc !== 32'h102) begin failures++; $display("FAIL mis_pc: got %h expected 00000102", pc); end
        for (int unsigned k = 0; k < 3; k++) begin
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_halt_req%0d: got %b expected 0", k, imem_req); end
            tick();
        end
        checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mis_sticky: got %b expected 1", misalign_err); end
`else
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_err: got %b expected 0", misalign_err); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL mis_addr: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL mis_pc: got %h expected 00000100", pc); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin failures++; $display("FAIL mis_first: got valid=%b pc=%h expected valid=1 pc=00000100", instr_valid, instr_pc); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic [31:0] prev_tgt;
        logic        prev_pend;
        logic        prev_redirect;
        int unsigned pops;
        lat_lo = 0; lat_hi = 3;
        do_reset(1'b0);
        exp_pc = 32'h0; prev_addr = '0; prev_tgt = '0;
        prev_pend = 1'b0; prev_redirect = 1'b0; pops = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            instr_ready = ($urandom_range(9, 0) < 7);
            PCSrc       = ($urandom_range(99, 0) < 6);
            if ($urandom_range(3, 0) == 0)
                PCTarget = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(3, 0)), 2'b00};
            else
                PCTarget = {22'd0, 8'($urandom_range(255, 0)), 2'b00};
            if (prev_redirect) begin
                checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_flush@%0d: got %b expected 0", cyc, instr_valid); end
                checks++; if (pc !== prev_tgt) begin failures++; $display("FAIL rnd_pc@%0d: got %h expected %h", cyc, pc, prev_tgt); end
            end
            if (prev_pend) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin failures++; $display("FAIL rnd_addr_hold@%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, imem_req, imem_addr, prev_addr); end
            end
            if (instr_valid) begin
                checks++; if (instr_pc !== exp_pc) begin failures++; $display("FAIL rnd_head_pc@%0d: got %h expected %h", cyc, instr_pc, exp_pc); end
                checks++; if (instr_data !== mem_word(exp_pc)) begin failures++; $display("FAIL rnd_head_data@%0d: got %h expected %h", cyc, instr_data, mem_word(exp_pc)); end
                checks++; if (instr_pc_plus4 !== exp_pc + 32'd4) begin failures++; $display("FAIL rnd_plus4@%0d: got %h expected %h", cyc, instr_pc_plus4, exp_pc + 32'd4); end
            end
            prev_pend     = imem_req && !imem_ack;
            prev_addr     = imem_addr;
            prev_redirect = PCSrc;
            prev_tgt      = PCTarget;
            if (PCSrc) begin
                exp_pc = PCTarget;
            end else if (instr_valid && instr_ready) begin
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        PCSrc = 1'b0;
        checks++; if (pops < 40) begin failures++; $display("FAIL rnd_progress: got %0d pops expected at least 40", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_ack_pop();
        test_wrap();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
